// File: rtl/serial_frame_pkg.sv
// Shared definitions for the single-wire serial byte link (transmitter and receiver).
package serial_frame_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } frame_state_t;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, tick on the last cycle.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start / 8 data LSB-first / optional parity / stop bits,
// with a one-entry holding register so frames can run back-to-back.
//   state  | meaning
//   IDLE   | line at 1, waiting for a byte
//   START  | driving the start bit
//   DATA   | shifting out data bits, LSB first
//   PARITY | driving the parity bit computed at load
//   STOP   | driving stop bit(s); next byte may start with no gap
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy,
    output logic       tx_done
);

    frame_state_t         state, state_nx;
    logic [DATA_BITS-1:0] shift_q, shift_nx;
    logic [DATA_BITS-1:0] hold_data, hold_data_nx;
    logic [DATA_BITS-1:0] load_data;
    logic [2:0]           bit_idx, bit_idx_nx;
    logic                 hold_full, hold_full_nx;
    logic                 parity_q, parity_nx;
    logic                 line_q, line_nx;
    logic                 accept;
    logic                 load;
    logic                 tick;

    assign tx_ready   = !hold_full;
    assign accept     = tx_valid && !hold_full;
    assign busy       = (state != IDLE);
    assign serial_out = line_q;
    assign load_data  = hold_full ? hold_data : tx_data;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk (clk),
        .rst (rst),
        .run (state != IDLE),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            bit_idx   <= '0;
            parity_q  <= 1'b0;
            line_q    <= LINE_IDLE;
        end else begin
            state     <= state_nx;
            shift_q   <= shift_nx;
            hold_data <= hold_data_nx;
            hold_full <= hold_full_nx;
            bit_idx   <= bit_idx_nx;
            parity_q  <= parity_nx;
            line_q    <= line_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        shift_nx     = shift_q;
        hold_data_nx = hold_data;
        hold_full_nx = hold_full;
        bit_idx_nx   = bit_idx;
        parity_nx    = parity_q;
        tx_done      = 1'b0;
        load         = 1'b0;

        unique case (state)
            IDLE: begin
                if (hold_full || accept) load = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_nx   = DATA;
                    bit_idx_nx = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_nx   = PARITY_EN ? PARITY : STOP;
                        bit_idx_nx = '0;
                    end else begin
                        shift_nx   = shift_q >> 1;
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_nx = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        tx_done = 1'b1;
                        if (hold_full || accept) load = 1'b1;
                        else                     state_nx = IDLE;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A load consumes the holding register if full, otherwise the byte on the bus.
        if (load) begin
            state_nx     = START;
            shift_nx     = load_data;
            parity_nx    = calc_parity(load_data, PARITY_ODD);
            bit_idx_nx   = '0;
            hold_full_nx = 1'b0;
        end else if (accept) begin
            hold_full_nx = 1'b1;
            hold_data_nx = tx_data;
        end

        unique case (state_nx)
            START:   line_nx = START_LEVEL;
            DATA:    line_nx = shift_nx[0];
            PARITY:  line_nx = parity_nx;
            default: line_nx = LINE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: three configurations, scoreboard of expected frames.
`timescale 1ns/1ps
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b, data_c;
    logic [2:0] valid, ready, so, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_q[$];
    logic [11:0] rxq0[$], rxq1[$], rxq2[$];

    bit          m_act[3];
    int          m_cnt[3];
    logic [11:0] m_raw[3];

    always #5 clk = ~clk;

    // A: 4 clk/bit, no parity, 1 stop.  B: 4 clk/bit, even parity, 2 stop.  C: 1 clk/bit, odd parity, 1 stop.
    serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .serial_out(so[0]), .busy(busy[0]), .tx_done(done[0]));
    serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .serial_out(so[1]), .busy(busy[1]), .tx_done(done[1]));
    serial_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .tx_data(data_c), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .serial_out(so[2]), .busy(busy[2]), .tx_done(done[2]));

    function automatic int cpb_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int nb_of(input int i);
        return (i == 0) ? 10 : (i == 1) ? 12 : 11;
    endfunction

    // Expected line bits of a frame, bit 0 first; bits past the frame read as idle 1.
    function automatic logic [11:0] frame_raw(input logic [7:0] d, input bit pe, input bit po);
        logic [11:0] r;
        r      = 12'hFFF;
        r[0]   = 1'b0;
        r[8:1] = d;
        if (pe) r[9] = (^d) ^ po;
        return r;
    endfunction

    // Receiver model: finds the start edge and samples every bit mid-period.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_act[i] = 1'b0;
            end else begin
                if (!m_act[i] && so[i] == 1'b0) begin
                    m_act[i] = 1'b1;
                    m_cnt[i] = 0;
                    m_raw[i] = 12'hFFF;
                end
                if (m_act[i]) begin
                    if (m_cnt[i] % cpb_of(i) == cpb_of(i) / 2) begin
                        m_raw[i][m_cnt[i] / cpb_of(i)] = so[i];
                        if (m_cnt[i] / cpb_of(i) == nb_of(i) - 1) begin
                            m_act[i] = 1'b0;
                            case (i)
                                0:       rxq0.push_back(m_raw[i]);
                                1:       rxq1.push_back(m_raw[i]);
                                default: rxq2.push_back(m_raw[i]);
                            endcase
                        end
                    end
                    m_cnt[i]++;
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        case (i)
            0:       data_a = d;
            1:       data_b = d;
            default: data_c = d;
        endcase
        valid[i] = 1'b1;
        @(posedge clk);
        #1 valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 3'b000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({so, ready, busy, done} !== {3'b111, 3'b111, 3'b000, 3'b000}) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: so/rdy/busy/done=%b/%b/%b/%b want 111/111/000/000",
                         k, so, ready, busy, done);
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [11:0] r;
        logic [11:0] got;
        logic        es, ed, eb;
        int          nd;
        bit          ok;
        rxq0.delete();
        r = frame_raw(8'hA5, 1'b0, 1'b0);
        exp_q.push_back(r);
        send(0, 8'hA5, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL a5_accept: tx_ready never high"); end
        nd = 0;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            es = (k < 40) ? r[k / 4] : 1'b1;
            ed = (k == 39);
            eb = (k < 40);
            nd += int'(done[0]);
            n_cmp++;
            if ({so[0], done[0], busy[0]} !== {es, ed, eb}) begin
                n_err++;
                $display("FAIL a5_wave cycle %0d: so/done/busy=%b%b%b want %b%b%b",
                         k + 1, so[0], done[0], busy[0], es, ed, eb);
            end
        end
        n_cmp++;
        if (nd != 1) begin n_err++; $display("FAIL a5_done_count: got %0d want 1", nd); end
        r = exp_q.pop_front();
        n_cmp++;
        if (rxq0.size() == 0) begin
            n_err++; $display("FAIL a5_rx: no frame received, want %h", r);
        end else begin
            got = rxq0.pop_front();
            if (got !== r) begin n_err++; $display("FAIL a5_rx: got %h want %h", got, r); end
        end
    endtask

    task automatic test_parity();
        logic [11:0] rb, rc, exp, got;
        logic        es, ed;
        bit          ok;
        rxq1.delete();
        rxq2.delete();
        rb = frame_raw(8'h07, 1'b1, 1'b0);
        exp_q.push_back(rb);
        send(1, 8'h07, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL par_b_accept: tx_ready never high"); end
        for (int k = 0; k < 52; k++) begin
            @(negedge clk);
            es = (k < 48) ? rb[k / 4] : 1'b1;
            ed = (k == 47);
            n_cmp++;
            if ({so[1], done[1]} !== {es, ed}) begin
                n_err++;
                $display("FAIL par_b_wave cycle %0d: so/done=%b%b want %b%b", k + 1, so[1], done[1], es, ed);
            end
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (rxq1.size() == 0) begin
            n_err++; $display("FAIL par_even_07: no frame received, want %h", exp);
        end else begin
            got = rxq1.pop_front();
            if (got !== exp || got[9] !== 1'b1)
                begin n_err++; $display("FAIL par_even_07: got %h (parity %b) want %h (parity 1)", got, got[9], exp); end
        end

        rc = frame_raw(8'h07, 1'b1, 1'b1);
        exp_q.push_back(rc);
        send(2, 8'h07, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL par_c_accept: tx_ready never high"); end
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            es = (k < 11) ? rc[k] : 1'b1;
            ed = (k == 10);
            n_cmp++;
            if ({so[2], done[2]} !== {es, ed}) begin
                n_err++;
                $display("FAIL par_c_wave cycle %0d: so/done=%b%b want %b%b", k + 1, so[2], done[2], es, ed);
            end
        end
        exp = exp_q.pop_front();
        n_cmp++;
        if (rxq2.size() == 0) begin
            n_err++; $display("FAIL par_odd_07: no frame received, want %h", exp);
        end else begin
            got = rxq2.pop_front();
            if (got !== exp || got[9] !== 1'b0)
                begin n_err++; $display("FAIL par_odd_07: got %h (parity %b) want %h (parity 0)", got, got[9], exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  sq[$];
        logic [11:0] r[3];
        logic [11:0] exp, got;
        logic        es, er, eb, ed;
        bit          prev_acc, started;
        int          k;
        rxq0.delete();
        sq = '{8'h55, 8'hAA, 8'h33};
        foreach (sq[j]) begin
            r[j] = frame_raw(sq[j], 1'b0, 1'b0);
            exp_q.push_back(r[j]);
        end
        prev_acc = 1'b0;
        started  = 1'b0;
        k        = 0;
        for (int c = 0; c < 400 && k <= 120; c++) begin
            @(negedge clk);
            if (prev_acc) begin
                void'(sq.pop_front());
                started = 1'b1;
            end
            if (started) begin
                es = (k < 120) ? r[k / 40][(k % 40) / 4] : 1'b1;
                er = !((k >= 1 && k <= 39) || (k >= 41 && k <= 79));
                eb = (k < 120);
                ed = (k == 39 || k == 79 || k == 119);
                n_cmp++;
                if ({so[0], ready[0], busy[0], done[0]} !== {es, er, eb, ed}) begin
                    n_err++;
                    $display("FAIL b2b_wave k=%0d: so/rdy/busy/done=%b%b%b%b want %b%b%b%b",
                             k, so[0], ready[0], busy[0], done[0], es, er, eb, ed);
                end
                k++;
            end
            if (sq.size() > 0) begin
                data_a   = sq[0];
                valid[0] = 1'b1;
            end else begin
                valid[0] = 1'b0;
            end
            prev_acc = valid[0] && ready[0];
        end
        valid[0] = 1'b0;
        n_cmp++;
        if (k <= 120) begin n_err++; $display("FAIL b2b_timeout: checked %0d cycles want 121", k); end
        for (int j = 0; j < 3; j++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (rxq0.size() == 0) begin
                n_err++; $display("FAIL b2b_rx%0d: no frame received, want %h", j, exp);
            end else begin
                got = rxq0.pop_front();
                if (got !== exp) begin n_err++; $display("FAIL b2b_rx%0d: got %h want %h", j, got, exp); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] exp, got;
        bit          ok;
        rxq0.delete();
        send(0, 8'hFF, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rst_accept: tx_ready never high"); end
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            if (k == 0) begin
                data_a   = 8'h12;
                valid[0] = 1'b1;
            end
            if (k == 1) begin
                valid[0] = 1'b0;
                n_cmp++;
                if (ready[0] !== 1'b0) begin n_err++; $display("FAIL rst_hold_full: tx_ready=%b want 0", ready[0]); end
            end
            if (k == 16) begin
                n_cmp++;
                if ({so[0], busy[0]} !== 2'b11)
                    begin n_err++; $display("FAIL rst_bit3: so/busy=%b%b want 11", so[0], busy[0]); end
            end
            if (k == 17) rst = 1'b1;
            if (k == 18) begin
                n_cmp++;
                if ({so[0], ready[0], busy[0], done[0]} !== 4'b1100)
                    begin n_err++; $display("FAIL rst_abort: so/rdy/busy/done=%b%b%b%b want 1100",
                                            so[0], ready[0], busy[0], done[0]); end
                rst = 1'b0;
            end
        end
        exp = frame_raw(8'h3C, 1'b0, 1'b0);
        exp_q.push_back(exp);
        send(0, 8'h3C, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rst_3c_accept: tx_ready never high"); end
        for (int t = 0; t < 80 && rxq0.size() == 0; t++) @(negedge clk);
        exp = exp_q.pop_front();
        n_cmp++;
        if (rxq0.size() == 0) begin
            n_err++; $display("FAIL rst_3c_rx: no frame received, want %h", exp);
        end else begin
            got = rxq0.pop_front();
            if (got !== exp) begin n_err++; $display("FAIL rst_3c_rx: got %h want %h", got, exp); end
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (rxq0.size() != 0 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_stale: extra frames=%0d busy=%b want 0 and 0", rxq0.size(), busy[0]);
        end
    endtask

    task automatic test_loopback_c1();
        logic [7:0]  bytes[3];
        logic [11:0] exp, got;
        bit          ok;
        rxq2.delete();
        bytes = '{8'h00, 8'hFF, 8'h81};
        foreach (bytes[j]) begin
            exp_q.push_back(frame_raw(bytes[j], 1'b1, 1'b1));
            send(2, bytes[j], ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL loop_accept%0d: tx_ready never high", j); end
        end
        for (int t = 0; t < 100 && rxq2.size() < 3; t++) @(negedge clk);
        foreach (bytes[j]) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (rxq2.size() == 0) begin
                n_err++; $display("FAIL loop_rx_%h: no frame received", bytes[j]);
            end else begin
                got = rxq2.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL loop_rx_%h: got data %h frame %h want data %h frame %h",
                             bytes[j], got[8:1], got, bytes[j], exp);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 3'b000;
        data_a = 8'h00;
        data_b = 8'h00;
        data_c = 8'h00;
        test_reset();
        test_frame_a5();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback_c1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched so far", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
